// File: rtl/pll_supervisor.sv
// pll_supervisor: PLL reset and lock supervisor.
// Pulses the PLL reset, debounces a synchronised lock indication, releases
// per-domain resets in staged order, and recovers on its own from lock loss
// or a lock timeout. Relock events and timeouts are reported to the host.
module pll_supervisor #(
  parameter int NUM_CH         = 2,
  parameter int LOCK_CYCLES    = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int RST_PULSE      = 8,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int CNT_W          = 8
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              force_reset,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              ready,
  output logic [CNT_W-1:0]  relock_count,
  output logic              timeout_err
);

  localparam int PULSE_W = $clog2(RST_PULSE + 1);
  localparam int DEB_W   = $clog2(LOCK_CYCLES + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STG_W   = $clog2(STAGE_GAP * NUM_CH + 1);

  // The entry edge counts as the first pulse cycle, so the pulse ends when
  // the counter reaches RST_PULSE. Out of rst_n the counter starts at zero,
  // which makes the first edge after reset the entry edge.
  localparam logic [PULSE_W-1:0] PULSE_END = PULSE_W'(RST_PULSE);
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(LOCK_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STG_W-1:0]   STG_LAST  = STG_W'(STAGE_GAP * NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_RUN
  } state_e;

  state_e               state_q, state_d;
  logic [PULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [STG_W-1:0]     stage_cnt_q, stage_cnt_d;
  logic                 sync1_q, sync1_d;
  logic                 lk_s_q, lk_s_d;
  logic                 pll_rst_q, pll_rst_d;
  logic [NUM_CH-1:0]    ch_rst_n_q, ch_rst_n_d;
  logic                 ready_q, ready_d;
  logic [CNT_W-1:0]     relock_q, relock_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 lk_s;

  assign lk_s = lk_s_q;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_comb begin
    sync1_d = pll_locked;
    lk_s_d  = sync1_q;
  end

  // Next-state, counters and registered outputs of the supervisor FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d       = state_q;
    pulse_cnt_d   = pulse_cnt_q;
    deb_cnt_d     = deb_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    stage_cnt_d   = stage_cnt_q;
    ch_rst_n_d    = ch_rst_n_q;
    relock_d      = relock_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      ST_PLL_RST: begin
        ch_rst_n_d = '0;
        if (pulse_cnt_q == PULSE_END) begin
          state_d   = ST_WAIT_LOCK;
          deb_cnt_d = '0;
          tmo_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        ch_rst_n_d = '0;
        if (lk_s && (deb_cnt_q == DEB_LAST)) begin
          state_d     = ST_RELEASE;
          stage_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // The PLL never settled: re-reset it and remember the event.
          state_d       = ST_PLL_RST;
          pulse_cnt_d   = PULSE_W'(1);
          timeout_err_d = 1'b1;
        end else begin
          deb_cnt_d = lk_s ? deb_cnt_q + DEB_W'(1) : '0;
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!lk_s) begin
          state_d    = ST_WAIT_LOCK;
          deb_cnt_d  = '0;
          tmo_cnt_d  = '0;
          ch_rst_n_d = '0;
          if (relock_q != '1) relock_d = relock_q + CNT_W'(1);
        end else begin
          stage_cnt_d = stage_cnt_q + STG_W'(1);
          for (int i = 0; i < NUM_CH; i++) begin
            if (stage_cnt_q == STG_W'(STAGE_GAP * (i + 1) - 1)) ch_rst_n_d[i] = 1'b1;
          end
          if (stage_cnt_q == STG_LAST) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // The PLL relocks by itself, so a lock loss only re-debounces.
        if (!lk_s) begin
          state_d    = ST_WAIT_LOCK;
          deb_cnt_d  = '0;
          tmo_cnt_d  = '0;
          ch_rst_n_d = '0;
          if (relock_q != '1) relock_d = relock_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = ST_PLL_RST;
        pulse_cnt_d = '0;
        ch_rst_n_d  = '0;
      end
    endcase

    // A host restart overrides lock loss and timeout and is not counted.
    if (force_reset) begin
      state_d       = ST_PLL_RST;
      pulse_cnt_d   = PULSE_W'(1);
      ch_rst_n_d    = '0;
      relock_d      = relock_q;
      timeout_err_d = timeout_err_q;
    end

    pll_rst_d = (state_d == ST_PLL_RST);
    ready_d   = (state_d == ST_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge refclk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    if (!rst_n) begin
      state_q       <= ST_PLL_RST;
      pulse_cnt_q   <= '0;
      deb_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      stage_cnt_q   <= '0;
      sync1_q       <= 1'b0;
      lk_s_q        <= 1'b0;
      pll_rst_q     <= 1'b1;
      ch_rst_n_q    <= '0;
      ready_q       <= 1'b0;
      relock_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pulse_cnt_q   <= pulse_cnt_d;
      deb_cnt_q     <= deb_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      stage_cnt_q   <= stage_cnt_d;
      sync1_q       <= sync1_d;
      lk_s_q        <= lk_s_d;
      pll_rst_q     <= pll_rst_d;
      ch_rst_n_q    <= ch_rst_n_d;
      ready_q       <= ready_d;
      relock_q      <= relock_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign ch_rst_n     = ch_rst_n_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Testbench for pll_supervisor: directed scenarios with fixed timing checks,
// then randomized lock/force/reset traffic, all compared every cycle against
// a phase-based reference model.
module tb_pll_supervisor;

  localparam int NUM_CH  = 3;
  localparam int LOCK    = 4;
  localparam int GAP     = 3;
  localparam int PULSE   = 2;
  localparam int TIMEOUT = 50;
  localparam int CNT_W   = 2;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_REL  = 2;
  localparam int PH_RUN  = 3;

  logic              refclk;
  logic              rst_n;
  logic              pll_locked;
  logic              force_reset;
  logic              pll_rst;
  logic [NUM_CH-1:0] ch_rst_n;
  logic              ready;
  logic [CNT_W-1:0]  relock_count;
  logic              timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase plus elapsed-cycle bookkeeping.
  int m_phase, m_left, m_wait, m_run, m_el, m_relock;
  bit m_err, m_s1, m_s2;

  pll_supervisor #(
    .NUM_CH(NUM_CH), .LOCK_CYCLES(LOCK), .STAGE_GAP(GAP),
    .RST_PULSE(PULSE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
    .force_reset(force_reset), .pll_rst(pll_rst), .ch_rst_n(ch_rst_n),
    .ready(ready), .relock_count(relock_count), .timeout_err(timeout_err)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic enter_rst();
    m_phase = PH_RST;
    m_left  = PULSE - 1;
  endtask

  task automatic lose_lock();
    m_phase = PH_WAIT;
    m_wait  = 0;
    m_run   = 0;
    if (m_relock < (1 << CNT_W) - 1) m_relock++;
  endtask

  // Advances the model by one refclk edge using the inputs seen at that edge.
  task automatic model_step();
    bit lk;
    if (!rst_n) begin
      m_phase = PH_RST; m_left = PULSE; m_wait = 0; m_run = 0; m_el = 0;
      m_relock = 0; m_err = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
      return;
    end
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    if (force_reset) begin
      enter_rst();
      return;
    end
    case (m_phase)
      PH_RST: begin
        if (m_left == 0) begin
          m_phase = PH_WAIT; m_wait = 0; m_run = 0;
        end else begin
          m_left--;
        end
      end
      PH_WAIT: begin
        m_run = lk ? m_run + 1 : 0;
        m_wait++;
        if (m_run >= LOCK) begin
          m_phase = PH_REL; m_el = 0;
        end else if (m_wait >= TIMEOUT) begin
          m_err = 1'b1;
          enter_rst();
        end
      end
      PH_REL: begin
        if (!lk) lose_lock();
        else begin
          m_el++;
          if (m_el >= GAP * NUM_CH) m_phase = PH_RUN;
        end
      end
      default: if (!lk) lose_lock();
    endcase
  endtask

  function automatic logic [NUM_CH-1:0] exp_ch();
    logic [NUM_CH-1:0] v = '0;
    for (int i = 0; i < NUM_CH; i++)
      v[i] = (m_phase == PH_RUN) || (m_phase == PH_REL && m_el >= GAP * (i + 1));
    return v;
  endfunction

  task automatic compare_model();
    check("model.pll_rst", 32'(pll_rst), 32'(m_phase == PH_RST));
    check("model.ch_rst_n", 32'(ch_rst_n), 32'(exp_ch()));
    check("model.ready", 32'(ready), 32'(m_phase == PH_RUN));
    check("model.relock_count", 32'(relock_count), 32'(m_relock));
    check("model.timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  // One refclk cycle: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    compare_model();
  endtask

  task automatic wait_ready(input string tag, input int max);
    int n = 0;
    while (ready !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(ready), 32'd1);
  endtask

  task automatic wait_ch(input string tag, input logic [NUM_CH-1:0] pat, input int max);
    int n = 0;
    while (ch_rst_n !== pat && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(ch_rst_n), 32'(pat));
  endtask

  initial begin
    int hold;
    rst_n = 1'b0; pll_locked = 1'b0; force_reset = 1'b0;

    // Reset values.
    repeat (3) tick();
    check("rst.pll_rst", 32'(pll_rst), 32'd1);
    check("rst.ch_rst_n", 32'(ch_rst_n), 32'd0);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.relock", 32'(relock_count), 32'd0);
    check("rst.timeout_err", 32'(timeout_err), 32'd0);

    // Nominal bring-up: PLL reset pulse, lock rises after edge 10.
    rst_n = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (t == 2) check("nom.pll_rst_e1", 32'(pll_rst), 32'd1);
      if (t == 3) check("nom.pll_rst_e2", 32'(pll_rst), 32'd0);
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 8)  check("nom.ch_e18", 32'(ch_rst_n), 32'd0);
      if (k == 9)  check("nom.ch_e19", 32'(ch_rst_n), 32'b001);
      if (k == 12) check("nom.ch_e22", 32'(ch_rst_n), 32'b011);
      if (k == 14) check("nom.ready_e24", 32'(ready), 32'd0);
      if (k == 15) begin
        check("nom.ch_e25", 32'(ch_rst_n), 32'b111);
        check("nom.ready_e25", 32'(ready), 32'd1);
        check("nom.timeout_err", 32'(timeout_err), 32'd0);
      end
    end

    // Glitchy lock: 3 highs, 1 low, then steady.
    pll_locked = 1'b0; force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    repeat (6) tick();
    pll_locked = 1'b1;
    repeat (3) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 14) check("glitch.no_early_ready", 32'(ready), 32'd0);
      if (k == 15) check("glitch.ready", 32'(ready), 32'd1);
    end
    check("glitch.relock", 32'(relock_count), 32'd0);

    // Lock loss in RUN, then restore.
    pll_locked = 1'b0;
    repeat (2) tick();
    check("loss.ready_e2", 32'(ready), 32'd1);
    tick();
    check("loss.ready_e3", 32'(ready), 32'd0);
    check("loss.ch_e3", 32'(ch_rst_n), 32'd0);
    check("loss.relock", 32'(relock_count), 32'd1);
    check("loss.pll_rst", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 15) check("loss.rerelease", 32'(ready), 32'd1);
    end

    // force_reset mid-RELEASE.
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    wait_ch("force.reach_001", 3'b001, 40);
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    check("force.ch", 32'(ch_rst_n), 32'd0);
    check("force.pll_rst", 32'(pll_rst), 32'd1);
    check("force.relock", 32'(relock_count), 32'd1);
    wait_ready("force.ready", 60);

    // force_reset coinciding with lock loss in RUN.
    pll_locked = 1'b0;
    repeat (2) tick();
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    check("force_loss.pll_rst", 32'(pll_rst), 32'd1);
    check("force_loss.ready", 32'(ready), 32'd0);
    check("force_loss.relock", 32'(relock_count), 32'd1);
    pll_locked = 1'b1;
    wait_ready("force_loss.ready_again", 60);

    // One more lock loss: relock_count to 2.
    pll_locked = 1'b0;
    repeat (3) tick();
    check("loss2.relock", 32'(relock_count), 32'd2);
    pll_locked = 1'b1;
    wait_ready("loss2.ready", 60);

    // Timeout: lock held low after a forced restart.
    pll_locked = 1'b0; force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    for (int k = 2; k <= 105; k++) begin
      tick();
      if (k == 52)  begin
        check("tmo.pll_rst_pre", 32'(pll_rst), 32'd0);
        check("tmo.err_pre", 32'(timeout_err), 32'd0);
      end
      if (k == 53)  begin
        check("tmo.pll_rst_1", 32'(pll_rst), 32'd1);
        check("tmo.err_set", 32'(timeout_err), 32'd1);
      end
      if (k == 54)  check("tmo.pll_rst_2", 32'(pll_rst), 32'd1);
      if (k == 55)  check("tmo.pll_rst_end", 32'(pll_rst), 32'd0);
      if (k == 104) check("tmo.repeat_pre", 32'(pll_rst), 32'd0);
      if (k == 105) check("tmo.repeat", 32'(pll_rst), 32'd1);
    end
    pll_locked = 1'b1;
    wait_ready("tmo.ready", 80);
    check("tmo.err_sticky", 32'(timeout_err), 32'd1);
    check("tmo.relock", 32'(relock_count), 32'd2);

    // rst_n pulse mid-RUN clears everything, then the sequence re-runs.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstrun.pll_rst", 32'(pll_rst), 32'd1);
    check("rstrun.ch", 32'(ch_rst_n), 32'd0);
    check("rstrun.ready", 32'(ready), 32'd0);
    check("rstrun.relock", 32'(relock_count), 32'd0);
    check("rstrun.err", 32'(timeout_err), 32'd0);
    wait_ready("rstrun.ready", 80);

    // Repeated losses saturate relock_count at 3.
    for (int j = 1; j <= 4; j++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      check("sat.relock", 32'(relock_count), 32'((j > 3) ? 3 : j));
      pll_locked = 1'b1;
      wait_ready("sat.ready", 60);
    end

    // Randomized traffic against the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        pll_locked = ~pll_locked;
        hold = pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 70));
      end
      hold--;
      force_reset = ($urandom_range(0, 99) == 0);
      rst_n       = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1; force_reset = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
